// File: rtl/window_3x3_gen.sv
// Raster-to-window converter: two line buffers plus a 3x3 shift window.
// Presents a registered neighbourhood one clock after each accepted pixel.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int DATA_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_frame_start,
    input  logic                          i_de,
    input  logic [DATA_WIDTH-1:0]         i_pixel,
    output logic [DATA_WIDTH-1:0]         PixelData_00,
    output logic [DATA_WIDTH-1:0]         PixelData_01,
    output logic [DATA_WIDTH-1:0]         PixelData_02,
    output logic [DATA_WIDTH-1:0]         PixelData_10,
    output logic [DATA_WIDTH-1:0]         PixelData_11,
    output logic [DATA_WIDTH-1:0]         PixelData_12,
    output logic [DATA_WIDTH-1:0]         PixelData_20,
    output logic [DATA_WIDTH-1:0]         PixelData_21,
    output logic [DATA_WIDTH-1:0]         PixelData_22,
    output logic                          o_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_cx,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_cy,
    output logic                          o_eof
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0]         r_in_x;
    logic [YW-1:0]         r_in_y;
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_win [3][3];
    logic                  r_valid;
    logic                  r_eof;
    logic [XW-1:0]         r_cx;
    logic [YW-1:0]         r_cy;

    logic [XW-1:0]         w_x;
    logic [YW-1:0]         w_y;
    logic                  w_last_x;
    logic                  w_last_y;
    logic                  w_win_ok;
    logic [DATA_WIDTH-1:0] w_lb1;
    logic [DATA_WIDTH-1:0] w_lb2;

    // A frame-start pulse retargets the pixel accepted in the same cycle to (0,0).
    assign w_x      = i_frame_start ? '0 : r_in_x;
    assign w_y      = i_frame_start ? '0 : r_in_y;
    assign w_last_x = (w_x == XW'(IMG_WIDTH - 1));
    assign w_last_y = (w_y == YW'(IMG_HEIGHT - 1));
    assign w_win_ok = i_de && !i_frame_start
                      && (w_x >= XW'(2)) && (w_y >= YW'(2));
    assign w_lb1    = r_lb1[w_x];
    assign w_lb2    = r_lb2[w_x];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_x <= '0;
            r_in_y <= '0;
        end else if (i_de) begin
            if (w_last_x) begin
                r_in_x <= '0;
                r_in_y <= w_last_y ? '0 : w_y + YW'(1);
            end else begin
                r_in_x <= w_x + XW'(1);
                r_in_y <= w_y;
            end
        end else if (i_frame_start) begin
            r_in_x <= '0;
            r_in_y <= '0;
        end
    end

    // Line buffers are never exposed before being refilled, so no reset.
    always_ff @(posedge clk) begin
        if (i_de) begin
            r_lb2[w_x] <= w_lb1;
            r_lb1[w_x] <= i_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (i_de) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb2;
            r_win[1][2] <= w_lb1;
            r_win[2][2] <= i_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_valid <= w_win_ok;
            r_eof   <= w_win_ok && w_last_x && w_last_y;
            if (w_win_ok) begin
                r_cx <= w_x - XW'(1);
                r_cy <= w_y - YW'(1);
            end
        end
    end

    assign PixelData_00 = r_win[0][0];
    assign PixelData_01 = r_win[0][1];
    assign PixelData_02 = r_win[0][2];
    assign PixelData_10 = r_win[1][0];
    assign PixelData_11 = r_win[1][1];
    assign PixelData_12 = r_win[1][2];
    assign PixelData_20 = r_win[2][0];
    assign PixelData_21 = r_win[2][1];
    assign PixelData_22 = r_win[2][2];
    assign o_valid      = r_valid;
    assign o_eof        = r_eof;
    assign o_cx         = r_cx;
    assign o_cy         = r_cy;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on an 8x6 image.
// Pixel value = offset + {y[3:0],x[3:0]}; offsets tell frames apart.
module tb_window_3x3_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_frame_start;
    logic        i_de;
    logic [11:0] i_pixel;
    logic [11:0] PixelData_00, PixelData_01, PixelData_02;
    logic [11:0] PixelData_10, PixelData_11, PixelData_12;
    logic [11:0] PixelData_20, PixelData_21, PixelData_22;
    logic        o_valid;
    logic [2:0]  o_cx;
    logic [2:0]  o_cy;
    logic        o_eof;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int neof   = 0;
    int exp_cx = 0;
    int exp_cy = 0;

    always #5 clk = ~clk;

    window_3x3_gen #(
        .IMG_WIDTH  (8),
        .IMG_HEIGHT (6),
        .DATA_WIDTH (12)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_frame_start (i_frame_start),
        .i_de          (i_de),
        .i_pixel       (i_pixel),
        .PixelData_00  (PixelData_00),
        .PixelData_01  (PixelData_01),
        .PixelData_02  (PixelData_02),
        .PixelData_10  (PixelData_10),
        .PixelData_11  (PixelData_11),
        .PixelData_12  (PixelData_12),
        .PixelData_20  (PixelData_20),
        .PixelData_21  (PixelData_21),
        .PixelData_22  (PixelData_22),
        .o_valid       (o_valid),
        .o_cx          (o_cx),
        .o_cy          (o_cy),
        .o_eof         (o_eof)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] px(input logic [11:0] ofs,
                                       input int x, input int y);
        return ofs + 12'(y * 16 + x);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_eof"}, o_eof, 0);
        chk({tag, "_cx"}, o_cx, 0);
        chk({tag, "_cy"}, o_cy, 0);
        chk({tag, "_00"}, PixelData_00, 0);
        chk({tag, "_11"}, PixelData_11, 0);
        chk({tag, "_22"}, PixelData_22, 0);
        chk({tag, "_02"}, PixelData_02, 0);
        chk({tag, "_20"}, PixelData_20, 0);
    endtask

    // One clock: drive inputs, take the edge, check the registered result.
    task automatic step(input logic de, input logic fs, input int k,
                        input logic [11:0] ofs);
        int   x;
        int   y;
        logic ev;
        x = k % 8;
        y = k / 8;
        i_de          = de;
        i_frame_start = fs;
        i_pixel       = de ? px(ofs, x, y) : 12'hABC;
        @(posedge clk);
        #1;
        i_de          = 1'b0;
        i_frame_start = 1'b0;
        ev = de && (x >= 2) && (y >= 2);
        chk("valid", o_valid, ev);
        chk("eof", o_eof, ev && (x == 7) && (y == 5));
        if (ev) begin
            nvalid++;
            exp_cx = x - 1;
            exp_cy = y - 1;
            chk("p00", PixelData_00, px(ofs, x - 2, y - 2));
            chk("p01", PixelData_01, px(ofs, x - 1, y - 2));
            chk("p02", PixelData_02, px(ofs, x,     y - 2));
            chk("p10", PixelData_10, px(ofs, x - 2, y - 1));
            chk("p11", PixelData_11, px(ofs, x - 1, y - 1));
            chk("p12", PixelData_12, px(ofs, x,     y - 1));
            chk("p20", PixelData_20, px(ofs, x - 2, y));
            chk("p21", PixelData_21, px(ofs, x - 1, y));
            chk("p22", PixelData_22, px(ofs, x,     y));
            if (x == 7 && y == 5) neof++;
        end
        chk("cx", o_cx, exp_cx);
        chk("cy", o_cy, exp_cy);
    endtask

    // Feed n pixels from raster index start, with optional random idle cycles.
    task automatic run(input logic [11:0] ofs, input int idle,
                       input logic fs_first, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            int g;
            k = (start + i) % 48;
            g = 0;
            while (g < 6 && int'($urandom_range(99)) < idle) begin
                step(1'b0, 1'b0, k, ofs);
                g++;
            end
            step(1'b1, fs_first && (i == 0), k, ofs);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        i_frame_start = 1'b0;
        i_de          = 1'b0;
        i_pixel       = '0;
        @(posedge clk);
        #1;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: full frame, no gaps
        nvalid = 0;
        run(12'h000, 0, 1'b0, 0, 19);
        chk("t1_first_cnt", nvalid, 1);
        chk("t1_first_00", PixelData_00, 12'h000);
        chk("t1_first_11", PixelData_11, 12'h011);
        chk("t1_first_22", PixelData_22, 12'h022);
        chk("t1_first_cx", o_cx, 1);
        chk("t1_first_cy", o_cy, 1);
        run(12'h000, 0, 1'b0, 19, 29);
        chk("t1_count", nvalid, 24);
        chk("t1_last_eof", o_eof, 1);
        chk("t1_last_cx", o_cx, 6);
        chk("t1_last_cy", o_cy, 4);
        chk("t1_last_22", PixelData_22, 12'h057);

        // 2: same frame with ~30% idle cycles
        nvalid = 0;
        run(12'h000, 30, 1'b0, 0, 48);
        chk("t2_count", nvalid, 24);

        // 3: frame start pulse after (5,3), then a fresh frame
        run(12'h100, 0, 1'b0, 0, 30);
        step(1'b0, 1'b1, 0, 12'h200);
        nvalid = 0;
        run(12'h200, 0, 1'b0, 0, 19);
        chk("t3_first_cnt", nvalid, 1);
        chk("t3_first_00", PixelData_00, 12'h200);
        run(12'h200, 0, 1'b0, 19, 29);
        chk("t3_count", nvalid, 24);

        // 6: frame start coincident with an accepted pixel
        run(12'h300, 0, 1'b0, 0, 12);
        nvalid = 0;
        run(12'h500, 0, 1'b1, 0, 19);
        chk("t6_first_cnt", nvalid, 1);
        chk("t6_first_00", PixelData_00, 12'h500);
        chk("t6_first_cx", o_cx, 1);
        chk("t6_first_cy", o_cy, 1);
        run(12'h500, 0, 1'b0, 19, 29);
        chk("t6_count", nvalid, 24);

        // 5: two frames back to back without frame start
        nvalid = 0;
        neof   = 0;
        run(12'h600, 0, 1'b0, 0, 96);
        chk("t5_count", nvalid, 48);
        chk("t5_eofs", neof, 2);

        // 4: async reset mid-frame after (4,4)
        run(12'h700, 0, 1'b0, 0, 37);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("t4_async");
        repeat (3) @(posedge clk);
        #1;
        chk_zero("t4_held");
        reset_n = 1'b1;
        exp_cx  = 0;
        exp_cy  = 0;
        nvalid  = 0;
        run(12'h800, 0, 1'b0, 0, 48);
        chk("t4_count", nvalid, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Raster-to-window converter. Takes one 12-bit pixel per accepted cycle in raster order and presents a registered 3x3 neighbourhood on nine parallel outputs.
- Those outputs feed the team's 3x3 kernel filters (Gaussian, Sobel and similar) directly.
- Sits between the camera/frame-buffer pixel stream and the filter stage. Holds the two previous image rows in internal line buffers.

Parameters:
- IMG_WIDTH, 320, pixels per line (>=3)
- IMG_HEIGHT, 240, lines per frame (>=3)
- DATA_WIDTH, 12, bits per pixel (RGB444)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_frame_start  in  1  one-cycle pulse; next accepted pixel is (0,0)
- i_de  in  1  pixel valid; i_pixel accepted on each clk edge with i_de=1
- i_pixel  in  DATA_WIDTH  pixel value
- PixelData_00..PixelData_22  out  DATA_WIDTH each (9 ports)  window, row-major; _rc is row r, column c; _00 is top-left
- o_valid  out  1  window outputs valid this cycle
- o_cx  out  $clog2(IMG_WIDTH)  x coordinate of the window centre (PixelData_11)
- o_cy  out  $clog2(IMG_HEIGHT)  y coordinate of the window centre
- o_eof  out  1  pulse with o_valid on the last window of the frame

Behaviour:
- Reset (reset_n=0, async): all outputs 0; in_x=in_y=0; window registers 0. Line-buffer contents are not reset. They are never exposed, because validity is gated by coordinates.
- Input counters in_x, in_y:
  - Advance only on accepted pixels.
  - in_x wraps IMG_WIDTH-1 -> 0, and in_y increments at that wrap.
  - in_y wraps IMG_HEIGHT-1 -> 0, so back-to-back frames work without i_frame_start.
- i_frame_start:
  - Forces in_x=in_y=0 and drives o_valid=0 next cycle.
  - If i_de=1 in the same cycle, that pixel is accepted as (0,0) of the new frame. The pixel is not dropped.
- Line buffers:
  - LB1 holds row y-1 and LB2 holds row y-2, each IMG_WIDTH x DATA_WIDTH.
  - On accepting pixel P at (x,y): read LB2[x] and LB1[x] (pre-write values), then write LB2[x]<=LB1[x] and LB1[x]<=P in the same edge.
  - Read-before-write is mandatory.
- Window shift, on each accepted pixel:
  - Columns shift left: col0<=col1, col1<=col2.
  - The new col2 = {LB2[x], LB1[x], P} for rows 0, 1, 2.
  - Window registers hold their value when i_de=0.
- o_valid:
  - Registered. Asserted on the cycle after accepting (x,y) iff x>=2 and y>=2 and no i_frame_start that cycle; otherwise 0.
  - Latency from pixel accept to window: 1 clk.
  - Window content is (x-2..x, y-2..y); o_cx=x-1, o_cy=y-1.
- Borders: centres on row 0, row IMG_HEIGHT-1, column 0 and column IMG_WIDTH-1 never produce o_valid.
  - Valid windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Row wrap: columns carried over from the end of the previous line are discarded, because x<2 gates o_valid.
- o_eof: asserted together with o_valid for the window at centre (IMG_WIDTH-2, IMG_HEIGHT-2); otherwise 0.
- o_cx, o_cy: update only when o_valid is asserted; otherwise hold.
- i_de gaps of any length, mid-line or between lines, do not change the outputs apart from o_valid deassertion.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, pixel = {y[3:0],x[3:0]} zero-extended to 12 bits):
1. Full frame, i_de always 1:
   - Exactly 24 o_valid pulses.
   - First pulse comes 1 clk after pixel (2,2): _00=0x000, _11=0x011, _22=0x022, o_cx=1, o_cy=1.
   - Last pulse: o_eof=1, o_cx=6, o_cy=4, _22=0x057.
2. Same frame with random i_de gaps (30% idle) -> identical sequence of 24 windows and coordinates; o_valid is never asserted on an idle-following cycle without an accept.
3. i_frame_start pulsed after pixel (5,3):
   - No o_valid until new-frame pixel (2,2).
   - Its window shows the new rows only (rows 0..2 of the new frame).
4. reset_n low for 3 cycles mid-frame at (4,4):
   - All outputs 0 immediately (async).
   - After release, the stream restarts at (0,0); 24 correct windows follow.
5. Two frames back-to-back, no i_frame_start -> 48 valid windows; the second frame's windows are identical to the first; o_eof pulses twice.
6. i_frame_start coincident with i_de=1 -> that pixel is counted as (0,0): the first window is centre (1,1) with _00 equal to that pixel.
